// File: rtl/unified_mem_port.sv
// Shared single-port word memory serving an instruction fetch port and a data load/store port.
// Optional macro UMEM_BYTE_WRITE_EN enables per-byte store gating through d_be.
module unified_mem_port #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              gnt_d_q, gnt_d_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_we;
  logic              pick_d;
  logic [BE_W-1:0]   wr_be;
  logic              unused_bits;

  logic [IDX_W-1:0]  i_idx, d_idx;
  assign i_idx = i_addr[IDX_W+OFF_W-1:OFF_W];
  assign d_idx = d_addr[IDX_W+OFF_W-1:OFF_W];

`ifdef UMEM_BYTE_WRITE_EN
  assign wr_be = be_q;
`else
  assign wr_be = {BE_W{1'b1}};
`endif

  // Offset/upper address bits alias away by design; be_q is dead without byte writes.
  assign unused_bits = ^{i_addr, d_addr, be_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_we    = 1'b0;
    pick_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On contention the side that did not win last time is served.
          pick_d   = d_req && (!i_req || !last_d_q);
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          addr_d   = pick_d ? d_idx : i_idx;
          we_d     = pick_d && d_we;
          be_d     = d_be;
          wdata_d  = d_wdata;
          cnt_d    = CNT_W'(WAIT_STATES);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          i_ack_d = !gnt_d_q;
          d_ack_d = gnt_d_q;
          if (we_q)         mem_we    = 1'b1;
          else if (gnt_d_q) d_rdata_d = mem[addr_q];
          else              i_rdata_d = mem[addr_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      gnt_d_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Array has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_be[k]) mem[addr_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
      end
    end
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_unified_mem_port.sv
// Randomized scoreboard bench for unified_mem_port against a transaction-level memory model.
module tb_unified_mem_port;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int WS    = 2;
  localparam int LAT   = 2 + WS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata;
  logic          i_ack, d_ack, busy;
  logic [DW-1:0] i_rdata, d_rdata;

  unified_mem_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_last_d;
  logic [DW-1:0] m_i_data, m_d_data;
  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wordOf(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  // Reference behaviour of one completed access, in service order.
  function automatic void modelServe(input bit is_d, input bit we, input logic [31:0] addr,
                                     input logic [3:0] be, input logic [31:0] wd);
    int w;
    logic [31:0] mask;
    w = wordOf(addr);
    if (is_d && we) begin
      mask = 32'hFFFF_FFFF;
`ifdef UMEM_BYTE_WRITE_EN
      mask = 32'h0;
      for (int k = 0; k < 4; k++) if (be[k]) mask = mask | (32'hFF << (8 * k));
`endif
      m_mem[w] = (m_mem[w] & ~mask) | (wd & mask);
      d_exp_q.push_back(m_d_data);
    end else if (is_d) begin
      m_d_data = m_mem[w];
      d_exp_q.push_back(m_d_data);
    end else begin
      m_i_data = m_mem[w];
      i_exp_q.push_back(m_i_data);
    end
    m_last_d = is_d;
  endfunction

  // kind: 0 = fetch only, 1 = data only, 2 = both at once. Called on a negedge in IDLE.
  task automatic applyStimulus(input int kind, input logic [31:0] ia, input logic [31:0] da,
                               input logic we, input logic [3:0] be, input logic [31:0] wd);
    bit want_i, want_d, win_d, got_i, got_d, scramble, drop;
    int ci, cd;
    want_i = (kind != 1);
    want_d = (kind != 0);
    win_d  = want_d && (!want_i || !m_last_d);
    i_req = want_i; i_addr = ia;
    d_req = want_d; d_addr = da; d_we = we; d_be = be; d_wdata = wd;
    if (win_d) begin
      modelServe(1'b1, we, da, be, wd);
      if (want_i) modelServe(1'b0, 1'b0, ia, 4'h0, 32'h0);
    end else begin
      modelServe(1'b0, 1'b0, ia, 4'h0, 32'h0);
      if (want_d) modelServe(1'b1, we, da, be, wd);
    end
    scramble = (kind != 2) && ($urandom_range(0, 1) == 1);
    drop     = (kind != 2) && ($urandom_range(0, 3) == 0);
    got_i = !want_i; got_d = !want_d; ci = -1; cd = -1;
    for (int c = 1; c <= 40 && !(got_i && got_d); c++) begin
      @(negedge clk);
      if (kind != 2) checkOutput("busy_during", 32'(busy), 32'(c <= LAT));
      if (i_ack && !got_i) begin got_i = 1; ci = c; i_req = 1'b0; end
      if (d_ack && !got_d) begin got_d = 1; cd = c; d_req = 1'b0; end
      if (c == 1 && scramble) begin
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
      end
      if (c == 1 && drop) begin i_req = 1'b0; d_req = 1'b0; end
    end
    if (!(got_i && got_d)) begin
      total++; bad++;
      $display("[TB] FAIL ack_timeout: got i=%0d d=%0d expected both acks", got_i, got_d);
      i_req = 1'b0; d_req = 1'b0;
    end else if (kind == 0) begin
      checkOutput("i_latency", 32'(ci), 32'(LAT));
    end else if (kind == 1) begin
      checkOutput("d_latency", 32'(cd), 32'(LAT));
    end else begin
      checkOutput("winner_latency", 32'(win_d ? cd : ci), 32'(LAT));
      checkOutput("loser_latency", 32'(win_d ? ci : cd), 32'(LAT + 3 + WS));
    end
    @(negedge clk);
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_i_ack"}, 32'(i_ack), 32'd0);
    checkOutput({tag, "_d_ack"}, 32'(d_ack), 32'd0);
    checkOutput({tag, "_i_rdata"}, i_rdata, 32'd0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every ack pops the oldest expectation for that port.
  always @(negedge clk) begin
    if (reset_n) begin
      if (i_ack) begin
        if (i_exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL i_ack_unexpected: got i_ack=1 expected no pending fetch");
        end else checkOutput("i_rdata", i_rdata, i_exp_q.pop_front());
      end
      if (d_ack) begin
        if (d_exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL d_ack_unexpected: got d_ack=1 expected no pending data access");
        end else checkOutput("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] abort_addr, old_word, hold_exp;
    reset_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    m_last_d = 1'b0; m_i_data = '0; m_d_data = '0;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < DEPTH; w++) applyStimulus(1, 0, 32'(w * 4), 1'b1, 4'hF, $urandom);

    applyStimulus(1, 0, 32'h0, 1'b1, 4'hF, 32'h2002_0005);
    applyStimulus(0, 32'h0, 0, 1'b0, 4'h0, 0);
    checkOutput("i_rdata_hold", i_rdata, 32'h2002_0005);

    applyStimulus(1, 0, 32'h54, 1'b1, 4'hF, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h54, 1'b0, 4'h0, 0);
    applyStimulus(1, 0, 32'h454, 1'b0, 4'h0, 0);
    checkOutput("alias_0x454", d_rdata, 32'hDEAD_BEEF);

    applyStimulus(1, 0, 32'h54, 1'b1, 4'h1, 32'h0000_0011);
    applyStimulus(1, 0, 32'h54, 1'b0, 4'h0, 0);
`ifdef UMEM_BYTE_WRITE_EN
    hold_exp = 32'hDEAD_BE11;
`else
    hold_exp = 32'h0000_0011;
`endif
    checkOutput("byte_store_reload", d_rdata, hold_exp);

    for (int r = 0; r < 4; r++) applyStimulus(2, 32'(r * 8), 32'(r * 4 + 64), 1'b0, 4'h0, 0);

    for (int r = 0; r < 300; r++)
      applyStimulus(int'($urandom_range(0, 2)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);

    // Abort a store in its second wait cycle; the old word must survive.
    abort_addr = 32'h0000_0128;
    old_word   = m_mem[wordOf(abort_addr)];
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = abort_addr; d_wdata = ~old_word;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    d_req = 1'b0;
    m_last_d = 1'b0; m_i_data = '0; m_d_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1, 0, abort_addr, 1'b0, 4'h0, 0);
    checkOutput("abort_old_word", d_rdata, old_word);
    applyStimulus(2, 32'h10, 32'h20, 1'b0, 4'h0, 0);

    repeat (3) @(negedge clk);
    checkOutput("i_queue_drained", 32'(i_exp_q.size()), 32'd0);
    checkOutput("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
